uart_autobaud: RTL and testbench

UART_AUTOBAUD -- requirements
Module: uart_autobaud

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync_edge.sv | 34 +++
 rtl/uart_autobaud.sv | 161 ++++++++++++++++
 tb/tb_uart_autobaud.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared widths, FSM states and calibration constants for the UART auto-baud block.
package uart_pkg;

  localparam int unsigned DVSR_W      = 11;
  localparam int unsigned INTV_W      = 15;
  localparam int unsigned TOTAL_W     = 18;
  localparam int unsigned CALC_W      = 19;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned CAL_EDGES   = 8;
  localparam int unsigned ROUND_CONST = 64;
  localparam int unsigned ROUND_SHIFT = 7;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IDLE,
    WAIT_FALL,
    MEASURE,
    CALC
  } state_t;

endpackage

// File: rtl/uart_sync_edge.sv
// Two-flop synchronizer for the asynchronous rx line plus a history flop for edge detection.
module uart_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  output logic rx_sync,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic hist;

  assign rx_sync = sync;

  // Synchronizer chain resets to the idle-high line level; edge pulses are registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta <= 1'b1;
      sync <= 1'b1;
      hist <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      meta <= rx_i;
      sync <= meta;
      hist <= sync;
      rise <= sync & ~hist;
      fall <= hist & ~sync;
    end
  end

endmodule

// File: rtl/uart_autobaud.sv
// Measures a 0x55 calibration character on rx and derives the 16x-oversampling baud divisor.
module uart_autobaud
  import uart_pkg::*;
#(
  parameter logic [DVSR_W-1:0] DVSR_DEFAULT = 11'd27,
  parameter logic [INTV_W-1:0] TIMEOUT      = 15'd32767
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rx_i,
  input  logic              start_i,
  output logic [DVSR_W-1:0] dvsr_o,
  output logic              locked_o,
  output logic              busy_o,
  output logic              err_o
);

  state_t               state, state_d;
  logic [INTV_W-1:0]    intv, intv_d;
  logic [INTV_W-1:0]    i0, i0_d;
  logic [TOTAL_W-1:0]   total, total_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [DVSR_W-1:0]    dvsr_d;
  logic                 locked_d;
  logic                 busy_d;
  logic                 err_d;

  logic                 rx_sync;
  logic                 rise;
  logic                 fall;
  logic                 edge_any;

  logic [INTV_W:0]      intv_ext;
  logic [INTV_W:0]      tol_lo;
  logic [INTV_W:0]      tol_hi;
  logic                 out_of_tol;
  logic                 last_edge;
  logic [CALC_W-1:0]    calc_sum;
  logic [CALC_W-1:0]    calc_res;
  logic                 res_bad;

  uart_sync_edge u_sync_edge (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .rx_i    (rx_i),
    .rx_sync (rx_sync),
    .rise    (rise),
    .fall    (fall)
  );

  // Interval window is +/-25% of the first interval; divisor is total/128 rounded.
  assign edge_any   = rise | fall;
  assign intv_ext   = {1'b0, intv};
  assign tol_lo     = {1'b0, i0} - {3'b000, i0[INTV_W-1:2]};
  assign tol_hi     = {1'b0, i0} + {3'b000, i0[INTV_W-1:2]};
  assign out_of_tol = (intv_ext < tol_lo) || (intv_ext > tol_hi);
  assign last_edge  = (cnt == CNT_W'(CAL_EDGES - 1));
  assign calc_sum   = CALC_W'(total) + CALC_W'(ROUND_CONST);
  assign calc_res   = calc_sum >> ROUND_SHIFT;
  assign res_bad    = (calc_res == '0) || (calc_res[CALC_W-1:DVSR_W] != '0);

  // State, counters and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      intv     <= '0;
      i0       <= '0;
      total    <= '0;
      cnt      <= '0;
      dvsr_o   <= DVSR_DEFAULT;
      locked_o <= 1'b0;
      busy_o   <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      state    <= state_d;
      intv     <= intv_d;
      i0       <= i0_d;
      total    <= total_d;
      cnt      <= cnt_d;
      dvsr_o   <= dvsr_d;
      locked_o <= locked_d;
      busy_o   <= busy_d;
      err_o    <= err_d;
    end
  end

  // Next-state logic: arm, wait for idle line, time 8 edges, then compute the divisor.
  always_comb begin
    state_d  = state;
    intv_d   = intv;
    i0_d     = i0;
    total_d  = total;
    cnt_d    = cnt;
    dvsr_d   = dvsr_o;
    locked_d = locked_o;
    err_d    = 1'b0;

    case (state)
      IDLE: begin
        if (start_i) begin
          state_d  = WAIT_IDLE;
          locked_d = 1'b0;
        end
      end

      WAIT_IDLE: begin
        if (rx_sync) begin
          state_d = WAIT_FALL;
        end
      end

      WAIT_FALL: begin
        if (fall) begin
          intv_d  = '0;
          total_d = '0;
          cnt_d   = '0;
          state_d = MEASURE;
        end
      end

      MEASURE: begin
        if (edge_any) begin
          total_d = total + TOTAL_W'(intv);
          cnt_d   = cnt + CNT_W'(1);
          intv_d  = INTV_W'(1);
          if (cnt == '0) begin
            i0_d = intv;
          end
          if ((cnt != '0) && out_of_tol) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (last_edge) begin
            state_d = CALC;
          end
        end else if (intv == TIMEOUT) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          intv_d = intv + INTV_W'(1);
        end
      end

      CALC: begin
        state_d = IDLE;
        if (res_bad) begin
          err_d = 1'b1;
        end else begin
          dvsr_d   = calc_res[DVSR_W-1:0];
          locked_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_uart_autobaud.sv
// Scoreboard bench for uart_autobaud: a line-level model predicts each measurement outcome.
module tb_uart_autobaud;

  localparam int TIMEOUT_TB = 6000;
  localparam int P115200    = 434;
  localparam int P9600      = 5208;

  typedef int seg_t[9];

  typedef struct {
    logic        err;
    logic [10:0] dvsr;
    logic        locked;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic        start;
  logic [10:0] dvsr;
  logic        locked;
  logic        busy;
  logic        err;

  int          checks;
  int          failures;
  exp_t        exp_q[$];

  int          m_dvsr;
  int          m_locked;

  logic        busy_prev;
  logic        err_prev;
  logic [10:0] dvsr_prev;

  uart_autobaud #(
    .DVSR_DEFAULT (11'd27),
    .TIMEOUT      (15'(TIMEOUT_TB))
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .rx_i     (rx),
    .start_i  (start),
    .dvsr_o   (dvsr),
    .locked_o (locked),
    .busy_o   (busy),
    .err_o    (err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: end of every measurement is the fall of busy; compare against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_prev = 1'b0;
      err_prev  = 1'b0;
      dvsr_prev = dvsr;
    end else begin
      if (err_prev) check("err_single_cycle", int'(err), 0);
      if (err) check("err_dvsr_hold", int'(dvsr), int'(dvsr_prev));
      if (busy_prev && !busy) begin
        check("pending_expectation", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("done_err", int'(err), int'(e.err));
          check("done_dvsr", int'(dvsr), int'(e.dvsr));
          check("done_locked", int'(locked), int'(e.locked));
        end
      end
      busy_prev = busy;
      err_prev  = err;
      dvsr_prev = dvsr;
    end
  end

  // Reference: intervals between line edges, first one opened at zero by the start edge.
  task automatic predict(input seg_t seg);
    int   meas[8];
    int   i0;
    int   tot;
    int   res;
    bit   bad;
    exp_t e;
    meas[0] = seg[0] - 1;
    for (int k = 1; k < 8; k++) meas[k] = seg[k];
    i0  = meas[0];
    tot = 0;
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tot += meas[k];
      if (k > 0 && (meas[k] < i0 - (i0 >> 2) || meas[k] > i0 + (i0 >> 2))) bad = 1'b1;
    end
    res = (tot + 64) / 128;
    if (!bad && (res == 0 || res > 2047)) bad = 1'b1;
    m_locked = 0;
    if (!bad) begin
      m_dvsr   = res;
      m_locked = 1;
    end
    e.err    = bad;
    e.dvsr   = 11'(m_dvsr);
    e.locked = 1'(m_locked);
    exp_q.push_back(e);
  endtask

  task automatic wait_not_busy(input string name, input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(busy), 0);
  endtask

  // Arms one measurement and drives start bit, 0x55 LSB first, then idles the line.
  task automatic measure(input seg_t seg, input bit poke_start);
    predict(seg);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    for (int j = 0; j < 9; j++) begin
      rx = (j % 2 == 0) ? 1'b0 : 1'b1;
      for (int c = 0; c < seg[j]; c++) begin
        start = (poke_start && j == 3 && c == seg[j] / 2) ? 1'b1 : 1'b0;
        @(negedge clk);
      end
    end
    start = 1'b0;
    rx    = 1'b1;
    repeat (40) @(negedge clk);
    wait_not_busy("measure_done", 200);
  endtask

  function automatic seg_t uniform(input int p);
    seg_t s;
    for (int j = 0; j < 8; j++) s[j] = p;
    s[8] = 16;
    return s;
  endfunction

  initial begin
    repeat (120000) @(posedge clk);
    $display("FAIL watchdog: got no finish expected finish before 120000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    seg_t s;
    int   n;
    int   p;
    int   k;
    checks   = 0;
    failures = 0;
    m_dvsr   = 27;
    m_locked = 0;
    rst_n    = 1'b0;
    rx       = 1'b1;
    start    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    check("reset_dvsr", int'(dvsr), 27);
    check("reset_locked", int'(locked), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_err", int'(err), 0);

    measure(uniform(P115200), 1'b1);
    measure(uniform(P9600), 1'b0);

    s    = uniform(P115200);
    s[4] = 651;
    measure(s, 1'b0);

    // Divisor would round to zero: must fail and keep the previous value.
    measure(uniform(6), 1'b0);

    // Line drops once and stays low: only the timeout can end the measurement.
    m_locked = 0;
    begin
      exp_t e;
      e.err    = 1'b1;
      e.dvsr   = 11'(m_dvsr);
      e.locked = 1'b0;
      exp_q.push_back(e);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b0;
    n  = 0;
    while (!err && n < TIMEOUT_TB + 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency_window", int'(n >= TIMEOUT_TB + 4 && n <= TIMEOUT_TB + 6), 1);
    check("timeout_idle", int'(busy), 0);
    rx = 1'b1;
    repeat (10) @(negedge clk);

    // Reset in the middle of MEASURE discards the measurement silently.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b0;
    repeat (P115200) @(negedge clk);
    rx = 1'b1;
    repeat (P115200) @(negedge clk);
    rx = 1'b0;
    repeat (200) @(negedge clk);
    check("pre_reset_busy", int'(busy), 1);
    #5 rst_n = 1'b0;
    #1;
    check("midreset_dvsr", int'(dvsr), 27);
    check("midreset_locked", int'(locked), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_err", int'(err), 0);
    m_dvsr   = 27;
    m_locked = 0;
    rx       = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    measure(uniform(P115200), 1'b0);
    check("relock_dvsr", int'(dvsr), 27);

    // Randomized rates, jittered bits and occasional out-of-tolerance bits.
    for (int r = 0; r < 5; r++) begin
      p = int'($urandom_range(40, 200));
      for (int j = 0; j < 8; j++) s[j] = p + int'($urandom_range(0, p / 5)) - p / 10;
      s[8] = 16;
      if (r % 2 == 1) begin
        k    = int'($urandom_range(1, 7));
        s[k] = ($urandom_range(0, 1) == 1) ? p + p / 2 + 2 : p - p / 2 - 2;
      end
      measure(s, (r % 2 == 0));
    end

    repeat (10) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
